kmeans_acc_block_kn: RTL and testbench

Parametrised successor of the fixed 4-centroid/2-dimension k-means accumulator. Sits after the distance/compare pipeline: for each incoming sample it adds every dimension into the per-centroid sum and increments that centroid's count. On request it drains one record per centroid (sums plus count) to the centroid-update stage through a valid/ready handshake, then clears itself for the next iteration. Unlike the previous generation it adds:
- saturation with a sticky overflow flag;
- back-to-back same-centroid hazard freedom;
- a self-contained drain/clear state machine.

---
 rtl/kmeans_pkg.sv | 28 ++
 rtl/kmeans_sat_add.sv | 21 ++
 rtl/kmeans_acc_block_kn.sv | 144 ++++++++++++++
 tb/tb_kmeans_acc_block_kn.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means accumulator: default widths, drain/clear
// state encoding and an elaboration-time log2 helper.
package kmeans_pkg;

  localparam int DEF_INPUT_DATA_WIDTH = 8;
  localparam int DEF_DIMS             = 2;
  localparam int DEF_CENTROIDS        = 4;
  localparam int DEF_CENTROID_BITS    = 2;
  localparam int DEF_ACC_WIDTH        = 16;
  localparam int DEF_COUNTER_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Smallest r with 2**r >= v; written as a bounded loop so it elaborates anywhere.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kmeans_sat_add.sv
// Combinational unsigned saturating adder: a + zero-extended b, clamped to
// all-ones with a flag when the result does not fit in a_width bits.
module kmeans_sat_add #(
  parameter int a_width = 16,
  parameter int b_width = 8
) (
  input  logic [a_width-1:0] a,
  input  logic [b_width-1:0] b,
  output logic [a_width-1:0] sum,
  output logic               sat
);

  logic [a_width:0] full;

  always_comb begin
    full = {1'b0, a} + {{(a_width + 1 - b_width){1'b0}}, b};
    sat  = full[a_width];
    sum  = sat ? '1 : full[a_width-1:0];
  end

endmodule

// File: rtl/kmeans_acc_block_kn.sv
// Per-centroid sum/count accumulator with saturation, sticky overflow and a
// drain-then-clear sequencer feeding the centroid-update stage.
module kmeans_acc_block_kn
  import kmeans_pkg::*;
#(
  parameter int input_data_width = DEF_INPUT_DATA_WIDTH,
  parameter int dims             = DEF_DIMS,
  parameter int centroids        = DEF_CENTROIDS,
  parameter int centroid_bits    = DEF_CENTROID_BITS,
  parameter int acc_width        = DEF_ACC_WIDTH,
  parameter int counter_width    = DEF_COUNTER_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              acc_valid,
  output logic                              acc_ready,
  input  logic [dims*input_data_width-1:0]  acc_data,
  input  logic [centroid_bits-1:0]          selected_centroid,
  input  logic                              drain_start,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [centroid_bits-1:0]          out_centroid,
  output logic [dims*acc_width-1:0]         out_sums,
  output logic [counter_width-1:0]          out_count,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
);

  localparam int IW = input_data_width;
  localparam int AW = acc_width;
  localparam int unsigned NC = centroids;
  localparam logic [centroid_bits-1:0] LAST_IDX = centroid_bits'(centroids - 1);

  state_e                   state_q, state_d;
  logic [centroid_bits-1:0] idx_q, idx_d;
  logic                     ovf_q, ovf_d;
  logic [AW-1:0]            sum_q [centroids][dims];
  logic [AW-1:0]            sum_d [centroids][dims];
  logic [counter_width-1:0] cnt_q [centroids];
  logic [counter_width-1:0] cnt_d [centroids];

  logic                     accept;
  logic                     sel_ok;
  logic [centroid_bits-1:0] sel_idx;
  logic [AW-1:0]            add_sum [dims];
  logic [dims-1:0]          add_sat;
  logic [counter_width-1:0] cnt_sum;
  logic                     cnt_sat;

  assign accept  = acc_valid && (state_q == ST_ACC);
  assign sel_ok  = (32'(selected_centroid) < NC);
  // Out-of-range indices are steered to entry 0 so the adders never read past the array.
  assign sel_idx = sel_ok ? selected_centroid : '0;

  for (genvar d = 0; d < dims; d++) begin : g_dim_add
    kmeans_sat_add #(.a_width(AW), .b_width(IW)) u_sum_add (
      .a   (sum_q[sel_idx][d]),
      .b   (acc_data[d*IW +: IW]),
      .sum (add_sum[d]),
      .sat (add_sat[d])
    );
  end

  kmeans_sat_add #(.a_width(counter_width), .b_width(1)) u_cnt_add (
    .a   (cnt_q[sel_idx]),
    .b   (1'b1),
    .sum (cnt_sum),
    .sat (cnt_sat)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACC: begin
        // A sample accepted alongside drain_start lands before the drain begins.
        if (accept) begin
          if (sel_ok) begin
            for (int d = 0; d < dims; d++) sum_d[sel_idx][d] = add_sum[d];
            cnt_d[sel_idx] = cnt_sum;
            if ((|add_sat) || cnt_sat) ovf_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (drain_start) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = ST_CLEAR;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        for (int c = 0; c < centroids; c++) begin
          cnt_d[c] = '0;
          for (int d = 0; d < dims; d++) sum_d[c][d] = '0;
        end
        idx_d   = '0;
        state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      for (int c = 0; c < centroids; c++) begin
        cnt_q[c] <= '0;
        for (int d = 0; d < dims; d++) sum_q[c][d] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state or read the arrays through the registered index.
  assign acc_ready    = (state_q == ST_ACC);
  assign out_valid    = (state_q == ST_DRAIN);
  assign busy         = (state_q != ST_ACC);
  assign done         = (state_q == ST_CLEAR);
  assign overflow     = ovf_q;
  assign out_centroid = idx_q;
  assign out_count    = out_valid ? cnt_q[idx_q] : '0;

  for (genvar d = 0; d < dims; d++) begin : g_out_sums
    assign out_sums[d*AW +: AW] = out_valid ? sum_q[idx_q][d] : '0;
  end

endmodule

// File: tb/tb_kmeans_acc_block_kn.sv
// Scoreboard bench for kmeans_acc_block_kn: a behavioural model predicts each
// drained record; a negedge monitor pops and compares as records are accepted.
module tb_kmeans_acc_block_kn;

  localparam int IW = 8, D = 2, C = 4, CB = 2, AW = 16, CW = 8;
  localparam int D5 = 3, C5 = 5, CB5 = 3;
  localparam int MAXS = (1 << AW) - 1;
  localparam int MAXC = (1 << CW) - 1;
  localparam int M_ONES = 0, M_TOGGLE = 1, M_RAND = 2, M_RST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, acc_valid, drain_start, out_ready;
  logic              acc_ready, out_valid, busy, done, overflow;
  logic [D*IW-1:0]   acc_data;
  logic [CB-1:0]     selected_centroid, out_centroid;
  logic [D*AW-1:0]   out_sums;
  logic [CW-1:0]     out_count;

  kmeans_acc_block_kn dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .selected_centroid(selected_centroid),
    .drain_start(drain_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_centroid(out_centroid), .out_sums(out_sums), .out_count(out_count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  logic              b_rst, b_acc_valid, b_drain_start, b_out_ready;
  logic              b_acc_ready, b_out_valid, b_busy, b_done, b_overflow;
  logic [D5*IW-1:0]  b_acc_data;
  logic [CB5-1:0]    b_sel, b_out_centroid;
  logic [D5*AW-1:0]  b_out_sums;
  logic [CW-1:0]     b_out_count;

  kmeans_acc_block_kn #(
    .input_data_width(IW), .dims(D5), .centroids(C5), .centroid_bits(CB5),
    .acc_width(AW), .counter_width(CW)
  ) dut5 (
    .clk(clk), .rst(b_rst), .acc_valid(b_acc_valid), .acc_ready(b_acc_ready),
    .acc_data(b_acc_data), .selected_centroid(b_sel),
    .drain_start(b_drain_start), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_centroid(b_out_centroid), .out_sums(b_out_sums), .out_count(b_out_count),
    .busy(b_busy), .done(b_done), .overflow(b_overflow)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer sums with clamping, no notion of state.
  typedef struct {
    int            c;
    logic [D*AW-1:0] sums;
    int            n;
  } rec_t;

  rec_t exp_q[$];
  int   m_sum [C][D];
  int   m_cnt [C];
  bit   m_ovf;

  task automatic model_clear();
    for (int c = 0; c < C; c++) begin
      m_cnt[c] = 0;
      for (int d = 0; d < D; d++) m_sum[c][d] = 0;
    end
  endtask

  task automatic model_accept(input logic [D*IW-1:0] data, input int c);
    int v;
    if (c >= C) begin
      m_ovf = 1'b1;
      return;
    end
    for (int d = 0; d < D; d++) begin
      v = m_sum[c][d] + int'(data[d*IW +: IW]);
      if (v > MAXS) begin v = MAXS; m_ovf = 1'b1; end
      m_sum[c][d] = v;
    end
    v = m_cnt[c] + 1;
    if (v > MAXC) begin v = MAXC; m_ovf = 1'b1; end
    m_cnt[c] = v;
  endtask

  task automatic model_snapshot();
    rec_t r;
    for (int c = 0; c < C; c++) begin
      r.c = c;
      r.n = m_cnt[c];
      for (int d = 0; d < D; d++) r.sums[d*AW +: AW] = AW'(m_sum[c][d]);
      exp_q.push_back(r);
    end
    model_clear();
  endtask

  // Monitor: pops on each accepted record and checks stability across stalls.
  rec_t            mon_r;
  logic            stall_prev = 1'b0;
  logic [CB-1:0]   h_c;
  logic [D*AW-1:0] h_s;
  logic [CW-1:0]   h_n;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (stall_prev) begin
        chk("hold_centroid", out_centroid, h_c);
        chk("hold_sums", out_sums, h_s);
        chk("hold_count", out_count, h_n);
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_record: got centroid %0d, expected no record", out_centroid);
        end else begin
          mon_r = exp_q.pop_front();
          chk("rec_centroid", out_centroid, mon_r.c);
          chk("rec_sums", out_sums, mon_r.sums);
          chk("rec_count", out_count, mon_r.n);
        end
      end
      stall_prev = !out_ready;
      h_c = out_centroid;
      h_s = out_sums;
      h_n = out_count;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [D*IW-1:0] data, input int c);
    cyc();
    acc_valid         = 1'b1;
    acc_data          = data;
    selected_centroid = CB'(c);
    if (acc_ready) model_accept(data, c);
  endtask

  task automatic idle();
    cyc();
    acc_valid = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    acc_valid = 1'b0;
    drain_start = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    m_ovf = 1'b0;
  endtask

  task automatic drain(input int mode, input bit with_sample,
                       input logic [D*IW-1:0] data, input int c);
    int  edges, ndone, k;
    bit  finished;
    edges = 0; ndone = 0; k = 0; finished = 0;
    cyc();
    drain_start = 1'b1;
    out_ready   = 1'b0;
    if (with_sample) begin
      acc_valid = 1'b1;
      acc_data = data;
      selected_centroid = CB'(c);
      model_accept(data, c);
    end else begin
      acc_valid = 1'b0;
    end
    model_snapshot();
    cyc();
    edges = 1;
    drain_start = 1'b0;
    acc_valid   = 1'b0;
    chk("out_valid_rises", out_valid, 1);
    chk("acc_ready_low_in_drain", acc_ready, 0);
    while (edges < 80) begin
      if (acc_ready) begin
        finished = 1;
        break;
      end
      if (done) ndone++;
      if (mode == M_RST && out_valid && out_centroid == 2) begin
        rst = 1'b1;
        out_ready = 1'b0;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_ready", acc_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        return;
      end
      case (mode)
        M_TOGGLE: out_ready = (k % 4 == 0) || (k % 4 == 3);
        M_RAND:   out_ready = (k % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        default:  out_ready = 1'b1;
      endcase
      k++;
      cyc();
      edges++;
    end
    chk("drain_finished", finished, 1);
    chk("done_pulses", ndone, 1);
    if (mode == M_ONES) chk("turnaround", edges, C + 2);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [D5*IW-1:0] bd;
    rst = 1'b1; acc_valid = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
    acc_data = '0; selected_centroid = '0;
    b_rst = 1'b1; b_acc_valid = 1'b0; b_drain_start = 1'b0; b_out_ready = 1'b1;
    b_acc_data = '0; b_sel = '0;
    model_clear();
    m_ovf = 1'b0;
    cyc();
    cyc();
    chk("rst_acc_ready", acc_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_centroid", out_centroid, 0);
    chk("rst_out_sums", out_sums, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Basic sequence: two samples to c1, one to c3.
    send({8'd5, 8'd3}, 1);
    send({8'd20, 8'd10}, 1);
    send({8'd7, 8'd7}, 3);
    idle();
    chk("basic_overflow", overflow, m_ovf);
    drain(M_ONES, 0, '0, 0);

    // Saturation of sum d0 and of the count.
    for (int i = 0; i < 300; i++) send({8'd1, 8'd255}, 0);
    idle();
    chk("sat_overflow", overflow, m_ovf);
    drain(M_ONES, 0, '0, 0);
    chk("overflow_sticky", overflow, 1);

    do_reset();
    chk("overflow_cleared_by_rst", overflow, 0);

    // Sample accepted in the drain_start cycle is included.
    drain(M_ONES, 1, {8'd2, 8'd2}, 0);

    // Random traffic, stalled drain.
    for (int i = 0; i < 40; i++) send(D*IW'($urandom), $urandom_range(0, C - 1));
    idle();
    chk("rand_overflow", overflow, m_ovf);
    drain(M_TOGGLE, 0, '0, 0);

    // Reset mid-drain, then a drain of an empty block.
    for (int i = 0; i < 20; i++) send(D*IW'($urandom), $urandom_range(0, C - 1));
    idle();
    drain(M_RST, 0, '0, 0);
    drain(M_ONES, 0, '0, 0);

    // Heavy random traffic concentrated on few centroids, random backpressure.
    for (int i = 0; i < 300; i++) send({8'($urandom_range(200, 255)), 8'($urandom)}, $urandom_range(1, 2));
    idle();
    chk("heavy_overflow", overflow, m_ovf);
    drain(M_RAND, 0, '0, 0);

    // Second configuration: out-of-range centroid index.
    b_rst = 1'b0;
    cyc();
    bd = D5*IW'($urandom);
    b_acc_valid = 1'b1;
    b_acc_data = bd;
    b_sel = 3'd6;
    cyc();
    b_acc_valid = 1'b0;
    cyc();
    chk("b_invalid_overflow", b_overflow, 1);
    b_drain_start = 1'b1;
    cyc();
    b_drain_start = 1'b0;
    for (int i = 0; i < C5; i++) begin
      chk("b_out_valid", b_out_valid, 1);
      chk("b_out_centroid", b_out_centroid, i);
      chk("b_out_count", b_out_count, 0);
      chk("b_out_sums", b_out_sums, 0);
      cyc();
    end
    chk("b_done", b_done, 1);
    cyc();
    chk("b_acc_ready", b_acc_ready, 1);
    chk("b_overflow_kept", b_overflow, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
